// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the E stage.
// Operands are latched on start; hi/lo update together when the fixed busy window ends.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               load_op, load_result, wr_hi_en, wr_lo_en;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Datapath works on latched operands, so input changes during RUN are harmless.
    logic               is_signed, a_neg, b_neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    assign prod      = {{WIDTH{a_neg}}, a_q} * {{WIDTH{b_neg}}, b_q};
    assign a_mag     = a_neg ? -a_q : a_q;
    assign b_mag     = b_neg ? -b_q : b_q;
    assign q_mag     = a_mag / b_mag;
    assign r_mag     = a_mag % b_mag;
    // MIN/-1 falls out naturally: magnitude quotient 2^(WIDTH-1) wraps back to src_a, rem 0.
    assign quot      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem       = a_neg ? -r_mag : r_mag;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q[1]) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == RUN);
        stall_req   = start | busy;
        load_op     = (state == IDLE) && start;
        load_result = (state == RUN) && (cnt == '0);
        wr_hi_en    = (state == IDLE) && !start && wr_hi;
        wr_lo_en    = (state == IDLE) && !start && wr_lo;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update in step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (load_op) begin
                op_q <= op;
                a_q  <= src_a;
                b_q  <= src_b;
                cnt  <= op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (load_result) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi_en) hi <= wr_data;
                if (wr_lo_en) lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: stimulus pushes expected hi/lo/busy-length into a
// scoreboard queue; a monitor pops and compares each time busy falls.
module tb_md_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0, wr_data = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right after a negedge; drives start for one cycle, returns at busy cycle 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit expect_res);
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (expect_res) sb.push_back('{eh, el, (o[1] ? 10 : 5)});
        #1 check("stall_req_on_start", {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        start = 1'b0; op = ~o; src_a = 32'hDEAD_BEEF; src_b = 32'h0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("wait_idle_timeout", {63'd0, done}, 64'd1);
    endtask

    // Monitor: counts busy cycles and compares on each falling edge of busy.
    initial begin
        int   run = 0;
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0; prev = 1'b0;
            end else if (busy) begin
                run++; prev = 1'b1;
            end else begin
                if (prev) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: hi=%0h lo=%0h with empty scoreboard", hi, lo);
                    end else begin
                        e = sb.pop_front();
                        check("busy_len", 64'(run), 64'(e.n));
                        check("result_hi", {32'd0, hi}, {32'd0, e.e_hi});
                        check("result_lo", {32'd0, lo}, {32'd0, e.e_lo});
                    end
                end
                prev = 1'b0; run = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // 1-2: multiplies
        launch(MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        wait_idle();
        launch(MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        wait_idle();
        launch(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1);
        wait_idle();

        // 3: signed divides including overflow and divisor sign
        launch(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_idle();
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
        wait_idle();
        launch(DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        wait_idle();
        launch(DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // 4: DIVU by zero, MTLO while busy dropped, MTLO/MTHI in idle
        launch(DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk); wr_lo = 1'b0;
        wait_idle();
        @(negedge clk);
        check("lo_after_busy_write", {32'd0, lo}, 64'hFFFF_FFFF);
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk); wr_lo = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h0000_1234);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h0000_0007);
        check("idle_stall", {63'd0, stall_req}, 64'd0);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_ABCD;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
        check("mt_both_hi", {32'd0, hi}, 64'h0000_ABCD);
        check("mt_both_lo", {32'd0, lo}, 64'h0000_ABCD);
        wr_hi = 1'b1; wr_data = 32'h0000_FFFF;
        launch(MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b1);
        wr_hi = 1'b0;
        check("mthi_with_start_dropped", {32'd0, hi}, 64'h0000_ABCD);
        wait_idle();

        // 5: start pulse mid-run ignored; back-to-back start on first idle cycle
        @(negedge clk);
        launch(DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        @(negedge clk);
        start = 1'b1; op = DIVU; src_a = 32'd55; src_b = 32'd3;
        @(negedge clk); start = 1'b0;
        wait_idle();
        launch(MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
        wait_idle();

        // 6: async reset mid-operation
        wr_hi = 1'b1; wr_data = 32'h0000_5555;
        @(negedge clk); wr_hi = 1'b0;
        check("hi_before_abort", {32'd0, hi}, 64'h0000_5555);
        launch(DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {63'd0, busy}, 64'd0);
        launch(MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1);
        wait_idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
